// File: rtl/inst_rom_resp.sv
// Instruction-fetch responder: word-addressed store with a program-load port,
// optional wait states with pipeline stall, and misalign/range error flags.
module inst_rom_resp #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic [31:0]           addr,
    input  logic                  prog_we,
    input  logic [DEPTH_LOG2-1:0] prog_addr,
    input  logic [31:0]           prog_data,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    output logic                  stall_req,
    output logic                  misalign_err,
    output logic                  range_err
);

    // state   | meaning
    // IDLE    | ready to accept a fetch; with no wait states the fetch answers next cycle
    // WAIT    | fetch accepted, counting down wait states while stalling the pipeline
    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0] WS_CNT = 4'(WAIT_STATES);

    logic [31:0] mem_q [DEPTH];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic        inst_valid_q, inst_valid_d;
    logic        misalign_q, misalign_d;
    logic        range_q, range_d;

    logic [31:0]           fetch_addr;
    logic                  fetch_mis;
    logic                  fetch_rng;
    logic [DEPTH_LOG2-1:0] fetch_idx;
    logic                  resp;

    // In IDLE the live address is used so zero-wait fetches answer next cycle.
    assign fetch_addr = (state_q == ST_IDLE) ? addr : addr_q;
    assign fetch_mis  = (fetch_addr[1:0] != 2'b00);
    assign fetch_rng  = (fetch_addr[31:DEPTH_LOG2+2] != '0);
    assign fetch_idx  = fetch_addr[DEPTH_LOG2+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        resp    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ce) begin
                    addr_d = addr;
                    if (WAIT_STATES == 0) begin
                        resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WS_CNT;
                    end
                end
            end
            ST_WAIT: begin
                if (!ce) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q - 4'd1;
                    resp    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        inst_d       = inst_q;
        inst_valid_d = 1'b0;
        misalign_d   = 1'b0;
        range_d      = 1'b0;
        if (resp) begin
            inst_valid_d = 1'b1;
            misalign_d   = fetch_mis;
            range_d      = fetch_rng;
            inst_d       = (fetch_mis || fetch_rng) ? 32'h0 : mem_q[fetch_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= 32'h0;
            inst_q       <= 32'h0;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            range_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            misalign_q   <= misalign_d;
            range_q      <= range_d;
        end
    end

    // Store is never reset; a same-edge write leaves the response with old data.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign inst         = inst_q;
    assign inst_valid   = inst_valid_q;
    assign stall_req    = (state_q == ST_WAIT);
    assign misalign_err = misalign_q;
    assign range_err    = range_q;

endmodule
